// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: RegWrite encodings and the
// hard-wired zero register.
package reg_wb_arbiter_pkg;

  localparam logic [1:0] RW_NONE = 2'b00;  // no register-file write
  localparam logic [1:0] RW_NORM = 2'b01;  // plain write of writedata
  localparam logic [1:0] RW_LUI  = 2'b10;  // register file shifts data into the upper half
  localparam int         REG_ZERO = 0;

  // RegWrite code for an accepted request; writes to r0 are swallowed.
  function automatic logic [1:0] rw_code(input logic lui, input logic is_r0);
    if (is_r0) return RW_NONE;
    return lui ? RW_LUI : RW_NORM;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_rr_pick.sv
// Round-robin priority picker: starting at ptr and wrapping, returns the
// first set bit of valid as a one-hot grant plus its index.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    logic [PW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % N);
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: shares the register file's single write port between
// NREQ requesters, registers the selected write, reports read hazards to
// decode and counts accepted requests.
//
// Handshake: a requester raises req_valid[i] with addr/data/lui stable and
// keeps them until it sees req_ready[i]=1 in the same cycle; the transfer
// happens at that posedge. req_ready is combinational, one-hot, never
// depends on ready from elsewhere, and is forced low by hold or reset.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_lui,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  output logic [1:0]        RegWrite,
  output logic [AW-1:0]     writeadd,
  output logic [DW-1:0]     writedata,
  input  logic [AW-1:0]     chk_addr1,
  input  logic [AW-1:0]     chk_addr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic [15:0]       grant_cnt
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gidx;
  logic            gany;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_data;
  logic            g_lui;

  // A frozen pipeline offers nothing to the picker.
  assign elig = hold ? '0 : req_valid;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .valid (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // No handshake can complete while reset is asserted.
  assign req_ready = rst_n ? grant : '0;

  // Mux out the winner's payload and the pointer that follows it.
  always_comb begin
    g_addr  = req_addr[int'(gidx)*AW +: AW];
    g_data  = req_data[int'(gidx)*DW +: DW];
    g_lui   = req_lui[gidx];
    ptr_nxt = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
  end

  // Pending-write check: any valid requester, granted or not, targeting a
  // non-zero read address. The output register is excluded because the
  // register file commits it on the negedge before decode reads.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && chk_addr1 != AW'(REG_ZERO) && req_addr[i*AW +: AW] == chk_addr1)
        hazard1 = 1'b1;
      if (req_valid[i] && chk_addr2 != AW'(REG_ZERO) && req_addr[i*AW +: AW] == chk_addr2)
        hazard2 = 1'b1;
    end
  end

  // Output register and round-robin pointer, advanced only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= RW_NONE;
      writeadd  <= '0;
      writedata <= '0;
      ptr       <= '0;
    end else if (gany) begin
      RegWrite  <= rw_code(g_lui, g_addr == AW'(REG_ZERO));
      writeadd  <= g_addr;
      writedata <= g_data;
      ptr       <= ptr_nxt;
    end else begin
      RegWrite  <= RW_NONE;
    end
  end

  // Saturating count of completed handshakes, r0 writes included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      grant_cnt <= '0;
    else if (gany && grant_cnt != 16'hFFFF)
      grant_cnt <= grant_cnt + 16'd1;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback requesters, e.g. ALU result, load data, LUI and JAL link.
- Per cycle: round-robin grant over valid/ready handshakes; drives a registered RegWrite/writeadd/writedata triple into the register file; tracks which register addresses still have pending writes so the decode stage can stall reads.
- Sits between the writeback sources and the register file.

Parameters:
- NREQ, 3, number of write requesters (2..4)
- AW, 5, register address width
- DW, 32, write data width

Ports:
- clk  in  1  system clock; outputs update on posedge; register file samples on negedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester write request
- req_lui  in  NREQ  per-requester: 1 = LUI-format write (register file performs the upper-half shift)
- req_addr  in  NREQ*AW  per-requester destination register, requester i at slice i
- req_data  in  NREQ*DW  per-requester write data, requester i at slice i
- req_ready  out  NREQ  one-hot grant, combinational, same cycle as the accepted valid
- hold  in  1  pipeline freeze: no grant while high
- RegWrite  out  2  to register file: 00 none, 01 normal write, 10 LUI write (11 never driven)
- writeadd  out  AW  to register file write address
- writedata  out  DW  to register file write data
- chk_addr1  in  AW  decode-stage read address 1
- chk_addr2  in  AW  decode-stage read address 2
- hazard1  out  1  chk_addr1 has an outstanding write
- hazard2  out  1  chk_addr2 has an outstanding write
- grant_cnt  out  16  total accepted requests, saturating

Behaviour:
- Reset (async, rst_n=0):
  - RegWrite=00, writeadd=0, writedata=0.
  - Round-robin pointer ptr=0, grant_cnt=0.
  - req_ready all 0 while in reset.
- Arbitration (combinational):
  - Scan requesters ptr, ptr+1, ... mod NREQ; the first with req_valid=1 is granted g.
  - req_ready[g]=1, all other ready bits 0.
  - hold=1 or no valid request: req_ready=0.
- Output register, at posedge:
  - Grant present: writeadd=req_addr[g], writedata=req_data[g], RegWrite = req_lui[g] ? 10 : 01. ptr = (g+1) mod NREQ.
  - No grant: RegWrite=00; writeadd and writedata hold their values; ptr unchanged.
  - Latency: request accepted at posedge k → RegWrite valid during cycle k → register file writes at negedge of cycle k → readable at posedge k+1.
- r0 protection: a granted request with req_addr=0 completes its handshake (ready=1, counted) but produces RegWrite=00.
- Requester order: a requester holding valid without ready keeps its addr/data/lui stable. The arbiter does not check this, but the bench does.
- Simultaneous same-address requests: served in round-robin order, one per cycle. The last granted value wins.
- Hazard:
  - hazardN=1 iff chk_addrN≠0 and some requester i has req_valid[i]=1 with req_addr[i]=chk_addrN.
  - This includes the requester being granted this cycle.
  - The entry already held in the output register does not raise a hazard, because it is written before the next posedge read.
- grant_cnt: +1 per handshake; saturates at 16'hFFFF.
- Reset mid-operation: the output register clears immediately, so no register-file write occurs on the following negedge. Requests that were not granted are lost; requesters re-present them after reset.
- hold during an active request: no grant; the output register drops to RegWrite=00 at the next posedge; ptr is frozen.

Decomposition:
- Shared package constants: RW_NONE=2'b00, RW_NORM=2'b01, RW_LUI=2'b10; REG_ZERO=0.
- Sub-module rr_pick: NREQ-wide round-robin priority picker taking valid and ptr, producing a one-hot grant and its index. Combinational, reusable by future arbiters.

Test Plan:
- Reset release, no requests → RegWrite=00 every cycle; req_ready=0; grant_cnt=0.
- Req0 alone, addr=8, data=32'h0000_0055, lui=0 → ready0=1 that cycle; next cycle RegWrite=01, writeadd=8, writedata=0x55; register 8 reads 0x55 one cycle later.
- Req0, req1 and req2 all valid continuously, addrs 9/10/11 → grants in order 0,1,2,0,...; RegWrite=01 every cycle; grant_cnt increments by 1 per cycle.
- Req1 with lui=1, addr=16, data=32'h0000_ABCD → RegWrite=10, writeadd=16; register 16 = 32'hABCD_0000.
- Req2 with addr=0, data=32'hFFFF_FFFF → ready2=1; RegWrite stays 00; register 0 stays 0; grant_cnt +1.
- Req0 valid, addr=12, while chk_addr1=12 and chk_addr2=0 → hazard1=1, hazard2=0. Assert hold=1 → no ready, RegWrite=00, hazard1 stays 1. Release hold → grant; hazard1=0 the cycle after the valid drops. Pulse rst_n low mid-stream → RegWrite=00 immediately, with no write at the next negedge.
